// File: rtl/xgmii_tx_pcs_encoder.sv
// XGMII TX PCS: 64b/66b block encoder, transmit block-sequence FSM and self-synchronizing
// scrambler, as a three-stage pipeline (classify, encode/FSM, scramble) on the XGMII TX clock.
module xgmii_tx_pcs_encoder #(
    parameter bit SCRAMBLE_BYPASS = 1'b0
) (
    input  logic        clk_xgmii_tx,
    input  logic        reset_xgmii_tx_n,
    input  logic [63:0] xgmii_txd,
    input  logic [7:0]  xgmii_txc,
    output logic [65:0] pcs_txd_66,
    output logic        pcs_tx_valid,
    output logic        status_tx_encode_err_tog,
    output logic [15:0] status_tx_encode_err_cnt,
    output logic [2:0]  dbg_tx_state_o
);

    typedef enum logic [2:0] {
        TX_INIT = 3'd0,
        TX_C    = 3'd1,
        TX_D    = 3'd2,
        TX_T    = 3'd3,
        TX_E    = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        CLS_C  = 3'd0,
        CLS_S0 = 3'd1,
        CLS_S4 = 3'd2,
        CLS_D  = 3'd3,
        CLS_T  = 3'd4,
        CLS_E  = 3'd5
    } cls_e;

    localparam logic [63:0] EBLOCK_PAY = {{8{7'h1E}}, 8'h1E};

    function automatic logic [7:0] t_type(input logic [2:0] k);
        logic [7:0] ty;
        case (k)
            3'd0:    ty = 8'h87;
            3'd1:    ty = 8'h99;
            3'd2:    ty = 8'hAA;
            3'd3:    ty = 8'hB4;
            3'd4:    ty = 8'hCC;
            3'd5:    ty = 8'hD2;
            3'd6:    ty = 8'hE1;
            default: ty = 8'hFF;
        endcase
        return ty;
    endfunction

    // Transmit block-sequence rules; anything landing in TX_E is replaced by an EBLOCK.
    function automatic tx_state_e fsm_next(input tx_state_e st, input cls_e cls);
        tx_state_e nxt;
        nxt = TX_E;
        case (st)
            TX_D: begin
                if (cls == CLS_D)      nxt = TX_D;
                else if (cls == CLS_T) nxt = TX_T;
            end
            TX_E: begin
                if (cls == CLS_D)      nxt = TX_D;
                else if (cls == CLS_C) nxt = TX_C;
                else if (cls == CLS_T) nxt = TX_T;
            end
            default: begin
                if (cls == CLS_C)                          nxt = TX_C;
                else if (cls == CLS_S0 || cls == CLS_S4)   nxt = TX_D;
            end
        endcase
        return nxt;
    endfunction

    // ---------------- Stage 1: register and classify ----------------
    cls_e        cls_d;
    cls_e        s1_cls_q;
    logic [2:0]  k_d;
    logic [2:0]  s1_k_q;
    logic [63:0] s1_txd_q;
    logic        s1_valid_q;
    logic        ctl_only_ie;
    logic        t_ok;

    always_comb begin
        cls_d       = CLS_E;
        k_d         = 3'd0;
        ctl_only_ie = 1'b1;
        t_ok        = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (xgmii_txd[8*i +: 8] != 8'h07 && xgmii_txd[8*i +: 8] != 8'hFE) ctl_only_ie = 1'b0;
        end
        if (xgmii_txc == 8'hFF && ctl_only_ie)                              cls_d = CLS_C;
        else if (xgmii_txc == 8'h01 && xgmii_txd[7:0] == 8'hFB)             cls_d = CLS_S0;
        else if (xgmii_txc == 8'h1F && xgmii_txd[39:0] == 40'hFB07070707)  cls_d = CLS_S4;
        else if (xgmii_txc == 8'h00)                                        cls_d = CLS_D;
        else begin
            for (int k = 0; k < 8; k++) begin
                t_ok = (xgmii_txc == (8'hFF << k)) && (xgmii_txd[8*k +: 8] == 8'hFD);
                for (int j = k + 1; j < 8; j++) begin
                    if (xgmii_txd[8*j +: 8] != 8'h07) t_ok = 1'b0;
                end
                if (t_ok) begin
                    cls_d = CLS_T;
                    k_d   = 3'(k);
                end
            end
        end
    end

    always_ff @(posedge clk_xgmii_tx or negedge reset_xgmii_tx_n) begin
        if (!reset_xgmii_tx_n) begin
            s1_valid_q <= 1'b0;
            s1_cls_q   <= CLS_E;
            s1_k_q     <= 3'd0;
            s1_txd_q   <= '0;
        end else begin
            s1_valid_q <= 1'b1;
            s1_cls_q   <= cls_d;
            s1_k_q     <= k_d;
            s1_txd_q   <= xgmii_txd;
        end
    end

    // ---------------- Stage 2: encode and sequence ----------------
    logic [63:0] enc_pay;
    logic [1:0]  enc_hdr;
    tx_state_e   state_q;
    tx_state_e   state_d;
    logic        s2_valid_q;
    logic        s2_err_q;
    logic [1:0]  s2_hdr_q;
    logic [63:0] s2_pay_q;

    always_comb begin
        enc_pay = EBLOCK_PAY;
        enc_hdr = 2'b01;
        unique case (s1_cls_q)
            CLS_C: begin
                enc_pay = {56'd0, 8'h1E};
                for (int i = 0; i < 8; i++) begin
                    enc_pay[8 + 7*i +: 7] = (s1_txd_q[8*i +: 8] == 8'hFE) ? 7'h1E : 7'h00;
                end
            end
            CLS_S0: enc_pay = {s1_txd_q[63:8], 8'h78};
            CLS_S4: enc_pay = {s1_txd_q[63:40], 32'd0, 8'h33};
            CLS_D: begin
                enc_hdr = 2'b10;
                enc_pay = s1_txd_q;
            end
            CLS_T: begin
                enc_pay = {56'd0, t_type(s1_k_q)};
                for (int i = 0; i < 7; i++) begin
                    if (3'(i) < s1_k_q) enc_pay[8 + 8*i +: 8] = s1_txd_q[8*i +: 8];
                end
            end
            default: enc_pay = EBLOCK_PAY;
        endcase
    end

    assign state_d        = fsm_next(state_q, s1_cls_q);
    assign dbg_tx_state_o = state_q;

    always_ff @(posedge clk_xgmii_tx or negedge reset_xgmii_tx_n) begin
        if (!reset_xgmii_tx_n) begin
            state_q    <= TX_INIT;
            s2_valid_q <= 1'b0;
            s2_err_q   <= 1'b0;
            s2_hdr_q   <= 2'b00;
            s2_pay_q   <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_hdr_q   <= enc_hdr;
            s2_pay_q   <= enc_pay;
            s2_err_q   <= s1_valid_q && (state_d == TX_E);
            if (s1_valid_q) state_q <= state_d;
        end
    end

    // ---------------- Stage 3: scramble payload (1 + x^39 + x^58) and register ----------------
    logic [63:0] scr_in;
    logic [63:0] scr_out;
    logic [57:0] scr_q;
    logic [57:0] scr_state;

    always_comb begin
        scr_in    = s2_err_q ? EBLOCK_PAY : s2_pay_q;
        scr_state = scr_q;
        scr_out   = '0;
        for (int i = 0; i < 64; i++) begin
            scr_out[i] = scr_in[i] ^ scr_state[38] ^ scr_state[57];
            scr_state  = {scr_state[56:0], scr_out[i]};
        end
    end

    always_ff @(posedge clk_xgmii_tx or negedge reset_xgmii_tx_n) begin
        if (!reset_xgmii_tx_n) begin
            pcs_txd_66               <= '0;
            pcs_tx_valid             <= 1'b0;
            status_tx_encode_err_tog <= 1'b0;
            status_tx_encode_err_cnt <= 16'd0;
            scr_q                    <= '1;
        end else begin
            pcs_tx_valid <= s2_valid_q;
            if (s2_valid_q) begin
                pcs_txd_66 <= {(SCRAMBLE_BYPASS ? scr_in : scr_out), (s2_err_q ? 2'b01 : s2_hdr_q)};
                if (!SCRAMBLE_BYPASS) scr_q <= scr_state;
                if (s2_err_q) begin
                    status_tx_encode_err_tog <= ~status_tx_encode_err_tog;
                    if (status_tx_encode_err_cnt != 16'hFFFF) begin
                        status_tx_encode_err_cnt <= status_tx_encode_err_cnt + 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_xgmii_tx_pcs_encoder.sv
// Bench for xgmii_tx_pcs_encoder: a bypass instance and a scrambling instance share one
// XGMII stream; a reference encoder/sequencer fills the expected-block queue.
module tb_xgmii_tx_pcs_encoder;

    localparam int ST_INIT = 0;
    localparam int ST_C    = 1;
    localparam int ST_D    = 2;
    localparam int ST_T    = 3;
    localparam int ST_E    = 4;

    localparam int K_C = 0;
    localparam int K_S = 1;
    localparam int K_D = 2;
    localparam int K_T = 3;
    localparam int K_E = 4;

    localparam logic [63:0] IDLE_W = 64'h0707070707070707;
    localparam logic [65:0] EBLK   = {{8{7'h1E}}, 8'h1E, 2'b01};

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] txd;
    logic [7:0]  txc;

    always #5 clk = ~clk;

    logic [65:0] byp_txd;
    logic        byp_valid;
    logic        byp_tog;
    logic [15:0] byp_cnt;
    logic [2:0]  byp_state;
    logic [65:0] scr_txd;
    logic        scr_valid;
    logic        scr_tog;
    logic [15:0] scr_cnt;
    logic [2:0]  scr_state;

    xgmii_tx_pcs_encoder #(.SCRAMBLE_BYPASS(1'b1)) dut_byp (
        .clk_xgmii_tx             (clk),
        .reset_xgmii_tx_n         (rst_n),
        .xgmii_txd                (txd),
        .xgmii_txc                (txc),
        .pcs_txd_66               (byp_txd),
        .pcs_tx_valid             (byp_valid),
        .status_tx_encode_err_tog (byp_tog),
        .status_tx_encode_err_cnt (byp_cnt),
        .dbg_tx_state_o           (byp_state)
    );

    xgmii_tx_pcs_encoder #(.SCRAMBLE_BYPASS(1'b0)) dut_scr (
        .clk_xgmii_tx             (clk),
        .reset_xgmii_tx_n         (rst_n),
        .xgmii_txd                (txd),
        .xgmii_txc                (txc),
        .pcs_txd_66               (scr_txd),
        .pcs_tx_valid             (scr_valid),
        .status_tx_encode_err_tog (scr_tog),
        .status_tx_encode_err_cnt (scr_cnt),
        .dbg_tx_state_o           (scr_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  t_types [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
    int          m_state;
    logic [15:0] m_cnt;
    logic        m_tog;
    logic [65:0] exp_q[$];
    logic [16:0] exp_st_q[$];

    function automatic int word_kind(input logic [63:0] d, input logic [7:0] c,
                                     output logic [65:0] blk);
        logic [7:0] b [8];
        logic       ok;
        for (int i = 0; i < 8; i++) b[i] = d[8*i +: 8];
        blk = '0;
        if (c == 8'hFF) begin
            ok = 1'b1;
            for (int i = 0; i < 8; i++) if (b[i] != 8'h07 && b[i] != 8'hFE) ok = 1'b0;
            if (ok) begin
                blk[1:0] = 2'b01;
                blk[9:2] = 8'h1E;
                for (int i = 0; i < 8; i++) blk[10 + 7*i +: 7] = (b[i] == 8'hFE) ? 7'h1E : 7'h00;
                return K_C;
            end
        end
        if (c == 8'h01 && b[0] == 8'hFB) begin
            blk = {d[63:8], 8'h78, 2'b01};
            return K_S;
        end
        if (c == 8'h1F && b[0] == 8'h07 && b[1] == 8'h07 && b[2] == 8'h07 && b[3] == 8'h07 &&
            b[4] == 8'hFB) begin
            blk = {d[63:40], 32'd0, 8'h33, 2'b01};
            return K_S;
        end
        if (c == 8'h00) begin
            blk = {d, 2'b10};
            return K_D;
        end
        for (int k = 0; k < 8; k++) begin
            logic [7:0] m;
            m  = 8'hFF << k;
            ok = (c == m) && (b[k] == 8'hFD);
            for (int j = k + 1; j < 8; j++) if (b[j] != 8'h07) ok = 1'b0;
            if (ok) begin
                blk[1:0] = 2'b01;
                blk[9:2] = t_types[k];
                for (int i = 0; i < k; i++) blk[10 + 8*i +: 8] = b[i];
                return K_T;
            end
        end
        return K_E;
    endfunction

    task automatic model_reset;
        m_state = ST_INIT;
        m_cnt   = 16'd0;
        m_tog   = 1'b0;
        exp_q.delete();
        exp_st_q.delete();
    endtask

    task automatic model_step(input logic [63:0] d, input logic [7:0] c,
                              output logic [65:0] blk, output logic [16:0] st);
        int kind;
        int nxt;
        kind = word_kind(d, c, blk);
        case (m_state)
            ST_D:    nxt = (kind == K_D) ? ST_D : (kind == K_T) ? ST_T : ST_E;
            ST_E:    nxt = (kind == K_D) ? ST_D : (kind == K_C) ? ST_C : (kind == K_T) ? ST_T : ST_E;
            default: nxt = (kind == K_C) ? ST_C : (kind == K_S) ? ST_D : ST_E;
        endcase
        if (nxt == ST_E) begin
            blk   = EBLK;
            m_tog = ~m_tog;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        m_state = nxt;
        st      = {m_tog, m_cnt};
    endtask

    // ---------------- driver ----------------
    task automatic send(input logic [63:0] d, input logic [7:0] c,
                        input logic use_lit, input logic [65:0] lit);
        logic [65:0] blk;
        logic [16:0] st;
        txd = d;
        txc = c;
        model_step(d, c, blk, st);
        exp_q.push_back(use_lit ? lit : blk);
        exp_st_q.push_back(st);
        @(posedge clk);
        #1;
    endtask

    task automatic send_m(input logic [63:0] d, input logic [7:0] c);
        send(d, c, 1'b0, '0);
    endtask

    task automatic release_and_check(input logic [63:0] d0, input logic [7:0] c0, input int st_after);
        rst_n = 1'b1;
        send_m(d0, c0);
        check("valid_edge1", byp_valid, 0);
        check("state_edge1", byp_state, ST_INIT);
        send_m(IDLE_W, 8'hFF);
        check("valid_edge2", byp_valid, 0);
        check("state_edge2", byp_state, st_after);
        send_m(IDLE_W, 8'hFF);
        check("valid_edge3", byp_valid, 1);
        check("scr_valid_edge3", scr_valid, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byp_txd"}, byp_txd, 0);
        check({tag, "_byp_valid"}, byp_valid, 0);
        check({tag, "_byp_cnt"}, byp_cnt, 0);
        check({tag, "_byp_tog"}, byp_tog, 0);
        check({tag, "_scr_txd"}, scr_txd, 0);
        check({tag, "_scr_valid"}, scr_valid, 0);
        check({tag, "_state"}, byp_state, ST_INIT);
    endtask

    // ---------------- scoreboard ----------------
    logic        sb_en = 1'b1;
    logic [57:0] ds_s;
    logic [63:0] mon_ds;
    logic [65:0] mon_exp;
    logic [16:0] mon_st;
    logic        ds_in;

    always @(negedge clk) begin
        if (!rst_n) begin
            ds_s = '1;
        end else if (sb_en && byp_valid) begin
            check("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                mon_st  = exp_st_q.pop_front();
                check("byp_block", byp_txd, mon_exp);
                check("byp_err_cnt", byp_cnt, mon_st[15:0]);
                check("byp_err_tog", byp_tog, mon_st[16]);
                check("scr_valid", scr_valid, 1);
                for (int i = 0; i < 64; i++) begin
                    ds_in     = scr_txd[2 + i];
                    mon_ds[i] = ds_in ^ ds_s[38] ^ ds_s[57];
                    ds_s      = {ds_s[56:0], ds_in};
                end
                check("scr_header", scr_txd[1:0], mon_exp[1:0]);
                check("scr_payload", mon_ds, mon_exp[65:2]);
                check("scr_err_cnt", scr_cnt, mon_st[15:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] d;
        logic [7:0]  c;
        int          k;
        rst_n = 1'b0;
        txd   = IDLE_W;
        txc   = 8'hFF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        release_and_check(IDLE_W, 8'hFF, ST_C);

        // idle
        send(IDLE_W, 8'hFF, 1'b1, {64'h1E, 2'b01});
        // frame: S0, data, T3, idle
        send(64'hD5555555555555FB, 8'h01, 1'b1, {64'hD555555555555578, 2'b01});
        send(64'h0123456789ABCDEF, 8'h00, 1'b1, {64'h0123456789ABCDEF, 2'b10});
        send(64'h07070707FDCCBBAA, 8'hF8, 1'b1, {64'h00000000CCBBAAB4, 2'b01});
        send(IDLE_W, 8'hFF, 1'b1, {64'h1E, 2'b01});
        // protocol error: data after idle, recover through idle, then start
        send(64'h1111111111111111, 8'h00, 1'b1, EBLK);
        send(IDLE_W, 8'hFF, 1'b1, {64'h1E, 2'b01});
        send(64'h66666666666666FB, 8'h01, 1'b1, {64'h6666666666666678, 2'b01});
        send(64'h2222222222222222, 8'h00, 1'b1, {64'h2222222222222222, 2'b10});
        check("state_after_start", byp_state, ST_D);
        send(64'h07070707070707FD, 8'hFF, 1'b1, {64'h87, 2'b01});
        // lane-4 start, T7 end, idle carrying /E/
        send(64'h332211FB07070707, 8'h1F, 1'b1, {64'h3322110000000033, 2'b01});
        send(64'hFD66554433221100, 8'h80, 1'b1, {64'h66554433221100FF, 2'b01});
        send_m(64'h070707FE07070707, 8'hFF);
        // frame aborted by idle in TX_D, then an illegal mixed word
        send_m(64'h77777777777777FB, 8'h01);
        send(IDLE_W, 8'hFF, 1'b1, EBLK);
        send_m(IDLE_W, 8'hFF);
        send(64'h0707070707070799, 8'hFF, 1'b1, EBLK);
        send_m(IDLE_W, 8'hFF);

        // random legal frames
        for (int f = 0; f < 1000; f++) begin
            d = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) begin
                d[7:0] = 8'hFB;
                send_m(d, 8'h01);
            end else begin
                d[39:0] = 40'hFB07070707;
                send_m(d, 8'h1F);
            end
            repeat ($urandom_range(0, 3)) send_m({$urandom, $urandom}, 8'h00);
            k = $urandom_range(0, 7);
            for (int i = 0; i < 8; i++) begin
                if (i < k)       d[8*i +: 8] = 8'($urandom_range(0, 255));
                else if (i == k) d[8*i +: 8] = 8'hFD;
                else             d[8*i +: 8] = 8'h07;
            end
            c = 8'hFF << k;
            send_m(d, c);
            repeat ($urandom_range(1, 2)) send_m(IDLE_W, 8'hFF);
        end

        // reset asserted during a data word
        send_m(64'h55555555555555FB, 8'h01);
        send_m(64'h0F0E0D0C0B0A0908, 8'h00);
        txd = 64'hDEADBEEFCAFEF00D;
        txc = 8'h00;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        release_and_check(64'hA5A5A5A5A5A5A5A5, 8'h00, ST_E);
        send_m(IDLE_W, 8'hFF);
        send_m(64'h44444444444444FB, 8'h01);
        send_m(64'h07070707070707FD, 8'hFF);
        send_m(IDLE_W, 8'hFF);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        sb_en = 1'b0;
        check("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/xgmii_tx_pcs_encoder.md
# xgmii_tx_pcs_encoder

Downstream of the TX dequeue stage. Consumes the 64-bit XGMII word stream (`xgmii_txd`/`xgmii_txc`) and produces one 66-bit block per clock for the serializer/gearbox. The block performs IEEE 802.3 Clause 49 64b/66b encoding, enforces the transmit block-sequence state machine, and applies the self-synchronizing scrambler. It runs entirely in the XGMII TX clock domain.

## Interface
Parameters:
- SCRAMBLE_BYPASS, 0, 1 = payload passes unscrambled (bench/debug only); sync header is never scrambled.

Ports:
- clk_xgmii_tx  input  1  XGMII TX clock. Single clock for the whole block.
- reset_xgmii_tx_n  input  1  reset; asynchronous, active-low.
- xgmii_txd  input  64  XGMII data. Lane k = bits [8k+7:8k]; lane 0 is transmitted first.
- xgmii_txc  input  8  per-lane control flag. txc[k] = 1 means lane k is a control character.
- pcs_txd_66  output  66  encoded block. [1:0] = sync header, bit 0 transmitted first; [65:2] = payload.
- pcs_tx_valid  output  1  pcs_txd_66 holds a valid block.
- status_tx_encode_err_tog  output  1  toggles once for every EBLOCK emitted.
- status_tx_encode_err_cnt  output  16  saturating count of EBLOCKs emitted.

## Operation
- Classification of each input word:
  - C: txc = FF and all lanes are /I/ (07) or /E/ (FE).
  - S: either
    - lane0 = FB, txc = 01; or
    - lanes 0-3 = /I/ (07), lane4 = FB, txc = 1F.
  - D: txc = 00.
  - T_k (k = 0..7): lanes 0..k-1 data, lane k = FD, lanes k+1..7 = /I/, txc = ~((1<<k)-1).
  - E: anything else.
- Encoding:
  - Data block: header 2'b10; payload = txd.
  - Control block: header 2'b01; payload[7:0] = block type.
    - C: type 1E; eight 7-bit codes in payload [63:8], with /I/ → 00 and /E/ → 1E.
    - S lane0: type 78; payload bytes 1-7 = lanes 1-7.
    - S lane4: type 33; four zero 7-bit codes, 4 zero bits, then lanes 5-7.
    - T_k: type = 87, 99, AA, B4, CC, D2, E1, FF for k = 0..7. Data lanes 0..k-1 go into payload bytes 1..k; the remaining bits are zero.
  - EBLOCK: type 1E with all eight codes = 1E.
- State machine states: TX_INIT, TX_C, TX_D, TX_T, TX_E.
  - TX_INIT: entered on reset. Next word: C→TX_C, S→TX_D, else TX_E.
  - TX_C and TX_T: C→TX_C, S→TX_D, T→TX_E, D→TX_E, E→TX_E.
  - TX_D: D→TX_D, T→TX_T, else TX_E.
  - TX_E: D→TX_D, C→TX_C, T→TX_T, else TX_E.
  - A word whose transition lands in TX_E is emitted as EBLOCK. Every other word is emitted as its own encoding.
  - Each EBLOCK toggles status_tx_encode_err_tog and increments status_tx_encode_err_cnt, which saturates at FFFF.
- Scrambler: polynomial 1 + x^39 + x^58, self-synchronizing, 58-bit state S.
  - Payload bits are processed in order, bit 2 (first transmitted) through bit 65.
  - out = in ^ S[38] ^ S[57]; S shifts in out each bit.
  - Header is passed through unscrambled.
  - With SCRAMBLE_BYPASS = 1, the payload is unchanged and S is held.

## Timing
- Pipeline:
  - Stage 1 registers txd/txc and classifies the word.
  - Stage 2 encodes it and updates the state machine.
  - Stage 3 scrambles and registers the outputs.
  - Latency is 3 cycles from input sample edge to pcs_txd_66. Throughput is one block per clock; no backpressure.
- Reset values:
  - pcs_txd_66 = 0, pcs_tx_valid = 0.
  - err_tog = 0, err_cnt = 0.
  - State = TX_INIT, S = all ones (58'h3FF_FFFF_FFFF_FFFF).
- After reset release, pcs_tx_valid rises on the 3rd rising edge and stays high.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously). The frame is discarded with no EBLOCK emitted for it.
- Counter increment and toggle happen on the same edge as the EBLOCK appears on pcs_txd_66.

## Test plan
- Idle, bypass = 1: txd = 0707070707070707, txc = FF → header 01, payload = 000...001E; err_cnt stays 0.
- Frame, bypass = 1: sequence
  1. start word: lane0 = FB, lanes 1-6 = 55, lane7 = D5, txc = 01
  2. data word: 0x0123456789ABCDEF, txc = 00
  3. T3 word: lanes 0-2 = AA BB CC, lane3 = FD, txc = F8
  4. idle

  Required output 3 cycles later:
  - type 78 block with payload bytes 1-7 = 55 ×6, D5
  - header 10 with payload 0x0123456789ABCDEF
  - type B4 block with bytes 1-3 = AA BB CC, rest 0
  - type 1E block
- Protocol error: data word (txc = 00) directly after idle → EBLOCK (type 1E, all codes 1E), err_tog flips, err_cnt = 1. Then a start word → type 78 block and state TX_D.
- Lane-4 start: lanes 0-3 = 07, lane4 = FB, lanes 5-7 = 11 22 33, txc = 1F → type 33 block with 11 22 33 in the top three payload bytes.
- Scrambler, bypass = 0: 1000 random legal frames → descrambling with a bench model seeded all-ones reproduces the bypass-mode payloads bit-exactly; headers are identical in both modes.
- Reset mid-frame: assert reset during a TX_D data word → outputs are 0 and valid = 0 immediately. After release, the first block is valid 3 edges later and the state machine starts from TX_INIT.
